match_ctrl: RTL and testbench

Round/match sequencer sitting directly downstream of the two `player` instances and upstream of their `reset`/`keycode` inputs. It watches both players' HP, declares round KOs, keeps score, and gates the shared keycode to the players. It also drives the players' respawn reset and exposes the game phase, scores and round result to the renderer/HUD.

---
 rtl/match_pkg.sv | 36 +++
 rtl/match_ctrl_if.sv | 32 +++
 rtl/frame_tick_sync.sv | 37 +++
 rtl/match_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_match_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/match_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_pkg
// Description : Shared types and helpers for the round/match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package match_pkg;

  typedef enum logic [2:0] {
    TITLE = 3'd0,
    SPAWN = 3'd1,
    PLAY  = 3'd2,
    KO    = 3'd3,
    OVER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P0   = 2'b01,
    WIN_P1   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  localparam logic [7:0] START_KEY_DEFAULT = 8'h28;

  // Negative HP (bit 9 set) is a transient underflow and counts as dead.
  function automatic logic is_dead(input logic [9:0] hp);
    return (hp == 10'd0) || hp[9];
  endfunction

  function automatic logic [2:0] score_inc(input logic [2:0] score);
    return (score == 3'd7) ? score : score + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/match_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl_if
// Description : Player/HUD-facing signal bundle of the match sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_ctrl_if;
  import match_pkg::*;

  logic [7:0] keycode;
  logic [9:0] hp0;
  logic [9:0] hp1;
  logic [7:0] keycode_out;
  logic       players_rst;
  state_t     state;
  logic [2:0] score0;
  logic [2:0] score1;
  winner_t    winner;
  logic [6:0] time_left;

  modport slave (
    input  keycode, hp0, hp1,
    output keycode_out, players_rst, state, score0, score1, winner, time_left
  );

  modport master (
    output keycode, hp0, hp1,
    input  keycode_out, players_rst, state, score0, score1, winner, time_left
  );

endinterface
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module      : frame_tick_sync
// Description : 2-flop synchronizer plus rising-edge detect of frame_clk,
//               giving a registered one-cycle tick in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  output logic tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : match_ctrl
// Description : Round/match sequencer: KO detection, scoring, player respawn
//               reset and keycode gating. Define MATCH_CTRL_TIMEOUT_EN to
//               enable the per-round time limit.
// Revision    : 1.0 - initial release
// ============================================================================
module match_ctrl
  import match_pkg::*;
#(
  parameter int         WIN_SCORE        = 3,
  parameter int         SPAWN_RST_FRAMES = 2,
  parameter int         COUNTDOWN_FRAMES = 90,
  parameter int         KO_FRAMES        = 120,
  parameter int         FRAMES_PER_SEC   = 60,
  parameter int         ROUND_SECONDS    = 60,
  parameter logic [7:0] START_KEY        = START_KEY_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_clk,
  match_ctrl_if.slave  bus
);

  localparam int CNT_MAX_A = (COUNTDOWN_FRAMES > KO_FRAMES) ? COUNTDOWN_FRAMES : KO_FRAMES;
  localparam int CNT_MAX   = (CNT_MAX_A > FRAMES_PER_SEC) ? CNT_MAX_A : FRAMES_PER_SEC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 7 || ROUND_SECONDS < 1 || ROUND_SECONDS > 127) begin : g_param_check
    $error("match_ctrl: WIN_SCORE or ROUND_SECONDS out of range");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_prev_key;
  logic [7:0]       r_keycode_out;
  logic             r_players_rst;
  logic [2:0]       r_score0;
  logic [2:0]       r_score1;
  winner_t          r_winner;
`ifdef MATCH_CTRL_TIMEOUT_EN
  logic [6:0]       r_time_left;
`endif

  logic             w_tick;
  logic             w_start_press;
  logic             w_dead0;
  logic             w_dead1;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_match_won;

  frame_tick_sync u_frame_tick_sync (
    .clk       (clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  assign w_start_press = (bus.keycode == START_KEY) && (r_prev_key != START_KEY);
  assign w_dead0       = is_dead(bus.hp0);
  assign w_dead1       = is_dead(bus.hp1);
  assign w_cnt_inc     = r_cnt + 1'b1;
  assign w_match_won   = (r_score0 >= 3'(WIN_SCORE)) || (r_score1 >= 3'(WIN_SCORE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= TITLE;
      r_cnt         <= '0;
      r_prev_key    <= 8'h00;
      r_keycode_out <= 8'h00;
      r_players_rst <= 1'b1;
      r_score0      <= 3'd0;
      r_score1      <= 3'd0;
      r_winner      <= WIN_NONE;
`ifdef MATCH_CTRL_TIMEOUT_EN
      r_time_left   <= 7'(ROUND_SECONDS);
`endif
    end else begin
      // Later assignments below override this on the ticks that enter/leave PLAY,
      // so the gate always follows the state being presented.
      r_keycode_out <= (r_state == PLAY) ? bus.keycode : 8'h00;

      if (w_tick) begin
        r_prev_key <= bus.keycode;
        case (r_state)
          TITLE, OVER: begin
            if (w_start_press) begin
              r_score0      <= 3'd0;
              r_score1      <= 3'd0;
              r_winner      <= WIN_NONE;
              r_state       <= SPAWN;
              r_cnt         <= '0;
              r_players_rst <= 1'b1;
            end
          end

          SPAWN: begin
            if (r_cnt == CNT_W'(COUNTDOWN_FRAMES - 1)) begin
              r_state       <= PLAY;
              r_cnt         <= '0;
              r_players_rst <= 1'b0;
              r_keycode_out <= bus.keycode;
`ifdef MATCH_CTRL_TIMEOUT_EN
              r_time_left   <= 7'(ROUND_SECONDS);
`endif
            end else begin
              r_cnt         <= w_cnt_inc;
              r_players_rst <= (w_cnt_inc < CNT_W'(SPAWN_RST_FRAMES));
            end
          end

          PLAY: begin
            if (w_dead0 || w_dead1) begin
              if (w_dead0 && w_dead1) begin
                r_winner <= WIN_DRAW;
              end else if (w_dead1) begin
                r_winner <= WIN_P0;
                r_score0 <= score_inc(r_score0);
              end else begin
                r_winner <= WIN_P1;
                r_score1 <= score_inc(r_score1);
              end
              r_state       <= KO;
              r_cnt         <= '0;
              r_keycode_out <= 8'h00;
            end
`ifdef MATCH_CTRL_TIMEOUT_EN
            else if (r_cnt == CNT_W'(FRAMES_PER_SEC - 1)) begin
              r_cnt       <= '0;
              r_time_left <= r_time_left - 7'd1;
              if (r_time_left == 7'd1) begin
                if (bus.hp0 > bus.hp1) begin
                  r_winner <= WIN_P0;
                  r_score0 <= score_inc(r_score0);
                end else if (bus.hp1 > bus.hp0) begin
                  r_winner <= WIN_P1;
                  r_score1 <= score_inc(r_score1);
                end else begin
                  r_winner <= WIN_DRAW;
                end
                r_state       <= KO;
                r_keycode_out <= 8'h00;
              end
            end else begin
              r_cnt <= w_cnt_inc;
            end
`endif
          end

          KO: begin
            if (r_cnt == CNT_W'(KO_FRAMES - 1)) begin
              r_cnt         <= '0;
              r_state       <= w_match_won ? OVER : SPAWN;
              r_players_rst <= !w_match_won;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end

          default: begin
            r_state       <= TITLE;
            r_cnt         <= '0;
            r_players_rst <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.keycode_out = r_keycode_out;
  assign bus.players_rst = r_players_rst;
  assign bus.state       = r_state;
  assign bus.score0      = r_score0;
  assign bus.score1      = r_score1;
  assign bus.winner      = r_winner;
`ifdef MATCH_CTRL_TIMEOUT_EN
  assign bus.time_left   = r_time_left;
`else
  assign bus.time_left   = 7'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_match_ctrl
// Description : Self-checking bench for match_ctrl: rule-level model compared
//               every cycle, plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_match_ctrl;
  import match_pkg::*;

`ifdef MATCH_CTRL_TIMEOUT_EN
  localparam int RS  = 2;
  localparam int FPS = 4;
  localparam int TIME_RESET = RS;
`else
  localparam int RS  = 60;
  localparam int FPS = 60;
  localparam int TIME_RESET = 0;
`endif
  localparam int SPAWN_RST = 2;
  localparam int CD_LEN    = 90;
  localparam int KO_LEN    = 120;
  localparam int WIN       = 3;

  logic clk = 1'b0;
  logic reset;
  logic frame_clk = 1'b0;
  always #5 clk = ~clk;

  match_ctrl_if bus ();

  match_ctrl #(
    .WIN_SCORE        (WIN),
    .SPAWN_RST_FRAMES (SPAWN_RST),
    .COUNTDOWN_FRAMES (CD_LEN),
    .KO_FRAMES        (KO_LEN),
    .FRAMES_PER_SEC   (FPS),
    .ROUND_SECONDS    (RS),
    .START_KEY        (8'h28)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase plus ticks elapsed in it, scores and last result.
  state_t     m_phase;
  int         m_elapsed, m_sub, m_s0, m_s1, m_win, m_time;
  logic [7:0] m_prev;

  function automatic bit dead(input logic [9:0] hp);
    return (hp == 0) || (hp >= 10'd512);
  endfunction

  function automatic int sat7(input int v);
    return (v >= 7) ? 7 : v + 1;
  endfunction

  task automatic model_reset();
    m_phase = TITLE; m_elapsed = 0; m_sub = 0;
    m_s0 = 0; m_s1 = 0; m_win = 0; m_time = TIME_RESET; m_prev = 8'h00;
  endtask

  task automatic enter(input state_t p);
    m_phase = p; m_elapsed = 0; m_sub = 0;
  endtask

  task automatic model_step();
    bit start;
    bit d0, d1;
    start  = (bus.keycode == 8'h28) && (m_prev != 8'h28);
    m_prev = bus.keycode;
    d0 = dead(bus.hp0);
    d1 = dead(bus.hp1);
    case (m_phase)
      TITLE, OVER: if (start) begin m_s0 = 0; m_s1 = 0; m_win = 0; enter(SPAWN); end
      SPAWN: begin
        m_elapsed++;
        if (m_elapsed == CD_LEN) begin enter(PLAY); m_time = TIME_RESET; end
      end
      PLAY: begin
        if (d0 && d1) begin m_win = 3; enter(KO); end
        else if (d1) begin m_s0 = sat7(m_s0); m_win = 1; enter(KO); end
        else if (d0) begin m_s1 = sat7(m_s1); m_win = 2; enter(KO); end
`ifdef MATCH_CTRL_TIMEOUT_EN
        else begin
          m_sub++;
          if (m_sub == FPS) begin
            m_sub = 0;
            m_time--;
            if (m_time == 0) begin
              if (bus.hp0 > bus.hp1)      begin m_s0 = sat7(m_s0); m_win = 1; end
              else if (bus.hp1 > bus.hp0) begin m_s1 = sat7(m_s1); m_win = 2; end
              else m_win = 3;
              enter(KO);
            end
          end
        end
`endif
      end
      KO: begin
        m_elapsed++;
        if (m_elapsed == KO_LEN) enter((m_s0 >= WIN || m_s1 >= WIN) ? OVER : SPAWN);
      end
      default: enter(TITLE);
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",       int'(bus.state),   int'(m_phase));
      check("players_rst", int'(bus.players_rst),
            int'(m_phase == TITLE || (m_phase == SPAWN && m_elapsed < SPAWN_RST)));
      check("score0",      int'(bus.score0),  m_s0);
      check("score1",      int'(bus.score1),  m_s1);
      check("winner",      int'(bus.winner),  m_win);
      check("time_left",   int'(bus.time_left), m_time);
      check("keycode_out", int'(bus.keycode_out),
            (m_phase == PLAY) ? int'(bus.keycode) : 0);
    end
  end

  // One frame_clk pulse; the model advances on the same clk edge as the DUT.
  task automatic tick();
    @(negedge clk); #1 frame_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1 model_step();
    @(negedge clk); #1 frame_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic run_to(input state_t p);
    for (int i = 0; i < 400 && m_phase != p; i++) tick();
    check("reach_state", int'(bus.state), int'(p));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.keycode = 8'h00; bus.hp0 = 10'd100; bus.hp1 = 10'd100;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk); #1;
    check("rst_state", int'(bus.state), 0);
    check("rst_players_rst", int'(bus.players_rst), 1);
    check("rst_keycode_out", int'(bus.keycode_out), 0);
    check("rst_time_left", int'(bus.time_left), TIME_RESET);
    chk_en = 1'b1;
    @(negedge clk); #1 reset = 1'b1;
    tick(); tick();

    // Start: Enter held for three ticks gives a single round start.
    bus.keycode = 8'h28;
    tick();
    check("start_spawn", int'(bus.state), 1);
    tick();
    check("spawn_rst_hold", int'(bus.players_rst), 1);
    tick();
    check("spawn_rst_release", int'(bus.players_rst), 0);
    bus.keycode = 8'h00;
    n = 3;
    for (int i = 0; i < 200 && m_phase == SPAWN; i++) begin
      tick();
      if (bus.state == SPAWN) n++;
    end
    check("spawn_len", n, CD_LEN);
    check("play_entry", int'(bus.state), 2);

    bus.keycode = 8'h1A; tick();
    bus.keycode = 8'h04; tick();
    check("fwd_key", int'(bus.keycode_out), 8'h04);

    // Negative HP on P1 counts as dead.
    bus.hp0 = 10'd50; bus.hp1 = 10'h3F6;
    tick();
    check("ko_winner", int'(bus.winner), 1);
    check("ko_score0", int'(bus.score0), 1);
    check("ko_keycode_out", int'(bus.keycode_out), 0);
    bus.hp0 = 10'd0; bus.hp1 = 10'd0;
    n = 1;
    for (int i = 0; i < 200 && m_phase == KO; i++) begin
      tick();
      if (bus.state == KO) n++;
    end
    check("ko_len", n, KO_LEN);
    check("ko_to_spawn", int'(bus.state), 1);

    // Dead HP during SPAWN is ignored; both dead on first PLAY tick is a draw.
    run_to(PLAY);
    bus.keycode = 8'h00;
    tick();
    check("draw_winner", int'(bus.winner), 3);
    check("draw_score0", int'(bus.score0), 1);
    check("draw_score1", int'(bus.score1), 0);

    // P0 takes two more rounds and the match.
    bus.hp0 = 10'd100; bus.hp1 = 10'd0;
    run_to(PLAY); tick();
    run_to(PLAY); tick();
    check("third_win", int'(bus.score0), 3);
    bus.keycode = 8'h28;
    run_to(OVER);
    check("over_score0", int'(bus.score0), 3);
    check("over_winner", int'(bus.winner), 1);
    repeat (5) tick();
    check("held_enter_no_restart", int'(bus.state), 4);
    bus.keycode = 8'h00; tick();
    bus.keycode = 8'h28; tick();
    check("restart_state", int'(bus.state), 1);
    check("restart_score0", int'(bus.score0), 0);
    check("restart_winner", int'(bus.winner), 0);
    bus.keycode = 8'h00;

    // Reset pulled mid-KO.
    run_to(PLAY); tick();
    tick(); tick();
    @(negedge clk); #1 reset = 1'b0; model_reset();
    @(negedge clk); #1;
    check("midko_state", int'(bus.state), 0);
    check("midko_score0", int'(bus.score0), 0);
    check("midko_players_rst", int'(bus.players_rst), 1);
    @(negedge clk); #1 reset = 1'b1;
    bus.hp0 = 10'd100; bus.hp1 = 10'd100;
    tick();

`ifdef MATCH_CTRL_TIMEOUT_EN
    bus.hp0 = 10'd80; bus.hp1 = 10'd60;
    bus.keycode = 8'h28; tick(); bus.keycode = 8'h00;
    run_to(PLAY);
    check("to_time_start", int'(bus.time_left), 2);
    repeat (4) tick();
    check("to_time_one", int'(bus.time_left), 1);
    repeat (4) tick();
    check("to_time_zero", int'(bus.time_left), 0);
    check("to_ko", int'(bus.state), 3);
    check("to_winner", int'(bus.winner), 1);
    bus.hp0 = 10'd70; bus.hp1 = 10'd70;
    run_to(PLAY);
    repeat (8) tick();
    check("to_draw", int'(bus.winner), 3);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
